// File: rtl/exp_pipe.sv
// Streaming fixed-point e^x: x splits into i (signed) and f (unsigned fraction),
// e^f comes from an ORDER-stage Horner pipeline and is scaled by an e^i table.

module exp_horner_stage #(
  parameter int              XW   = 8,
  parameter int              FW   = 4,
  parameter int              AW   = 26,
  parameter logic [AW-1:0]   COEF = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_adv,
  input  logic [XW-1:0] i_x,
  input  logic [AW-1:0] i_acc,
  output logic [XW-1:0] o_x,
  output logic [AW-1:0] o_acc
);
  logic [FW+AW-1:0] w_prod;
  logic [AW-1:0]    w_next;
  logic [XW-1:0]    r_x;
  logic [AW-1:0]    r_acc;

  // f has FW fraction bits, so dropping them truncates the product back to Q2.CF
  assign w_prod = (FW+AW)'(i_x[FW-1:0]) * (FW+AW)'(i_acc);
  assign w_next = COEF + AW'(w_prod >> FW);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_x   <= '0;
      r_acc <= '0;
    end else if (i_adv) begin
      r_x   <= i_x;
      r_acc <= w_next;
    end
  end

  assign o_x   = r_x;
  assign o_acc = r_acc;
endmodule

module exp_pipe #(
  parameter int INT_WIDTH      = 4,
  parameter int FRAC_WIDTH     = 4,
  parameter int ORDER          = 5,
  parameter int COEFF_FRAC     = 24,
  parameter int OUT_INT_WIDTH  = 16,
  parameter int OUT_FRAC_WIDTH = 16
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [INT_WIDTH+FRAC_WIDTH-1:0]         in_data,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  output logic [OUT_INT_WIDTH+OUT_FRAC_WIDTH-1:0] out_data,
  output logic                                    out_ovf,
  output logic                                    out_valid,
  input  logic                                    out_ready
);
  localparam int XW     = INT_WIDTH + FRAC_WIDTH;
  localparam int FW     = FRAC_WIDTH;
  localparam int IW     = INT_WIDTH;
  localparam int CF     = COEFF_FRAC;
  localparam int AW     = 2 + CF;
  localparam int LW     = OUT_INT_WIDTH + 1 + CF;
  localparam int OW     = OUT_INT_WIDTH + OUT_FRAC_WIDTH;
  localparam int PW     = AW + LW;
  localparam int SH     = 2*CF - OUT_FRAC_WIDTH;
  localparam int NLUT   = 2**IW;
  localparam int STAGES = ORDER + 1;
  localparam int EP     = 64;

  function automatic logic [AW-1:0] coeff(input int k);
    logic [63:0] fct;
    fct = 64'd1;
    for (int n = 2; n <= k; n++) fct = fct * 64'(n);
    return AW'(((64'd1 << CF) + fct / 64'd2) / fct);
  endfunction

  // e^i built from a 2^-64 series for e (or 1/e), then rounded to CF bits
  function automatic logic [LW-1:0] lut_entry(input int i);
    logic [191:0] one, e_p, term, v, r;
    int           n;
    one  = 192'd1 << EP;
    e_p  = '0;
    term = one;
    for (int k = 0; k < 40; k++) begin
      if (i < 0 && k[0]) e_p = e_p - term;
      else               e_p = e_p + term;
      term = term / 192'(k + 1);
    end
    n = (i < 0) ? -i : i;
    v = one;
    for (int k = 0; k < NLUT; k++)
      if (k < n && (v >> (EP + LW)) == 0) v = (v * e_p) >> EP;
    r = (v + (one >> (CF + 1))) >> (EP - CF);
    if ((r >> LW) != 0) return '1;
    return LW'(r);
  endfunction

  logic [STAGES:0]           r_vld_pipe;
  logic [XW-1:0]             r_x0;
  logic [OW-1:0]             r_out_data;
  logic                      r_out_ovf;
  logic                      w_adv;
  logic [ORDER:0][XW-1:0]    w_x;
  logic [ORDER:0][AW-1:0]    w_acc;
  logic [NLUT-1:0][LW-1:0]   w_lut;
  logic [IW-1:0]             w_idx;
  logic [PW-1:0]             w_prod;
  logic [PW:0]               w_sum;
  logic [PW-SH:0]            w_rnd;
  logic                      w_ovf;
  logic [OW-1:0]             w_out;
  logic                      w_unused;

  assign w_adv     = !r_vld_pipe[STAGES] || out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_vld_pipe[STAGES];
  assign out_data  = r_out_data;
  assign out_ovf   = r_out_ovf;

  assign w_x[0]   = r_x0;
  assign w_acc[0] = coeff(ORDER);

  for (genvar j = 1; j <= ORDER; j++) begin : g_horner
    exp_horner_stage #(
      .XW(XW), .FW(FW), .AW(AW), .COEF(coeff(ORDER - j))
    ) u_stage (
      .clk(clk), .rst(rst), .i_adv(w_adv),
      .i_x(w_x[j-1]), .i_acc(w_acc[j-1]),
      .o_x(w_x[j]),   .o_acc(w_acc[j])
    );
  end

  for (genvar g = 0; g < NLUT; g++) begin : g_lut
    localparam logic [LW-1:0] LV = lut_entry(g - 2**(IW-1));
    assign w_lut[g] = LV;
  end

  // flipping the sign bit maps signed i onto table index i + 2^(IW-1)
  assign w_idx    = w_x[ORDER][XW-1:FW] ^ (IW'(1) << (IW-1));
  assign w_unused = ^w_x[ORDER][FW-1:0];
  assign w_prod   = PW'(w_acc[ORDER]) * PW'(w_lut[w_idx]);
  assign w_sum    = {1'b0, w_prod} + ((PW+1)'(1) << (SH-1));
  assign w_rnd    = (PW-SH+1)'(w_sum >> SH);
  assign w_ovf    = |w_rnd[PW-SH:OW];
  assign w_out    = w_ovf ? '1 : w_rnd[OW-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld_pipe <= '0;
      r_x0       <= '0;
      r_out_data <= '0;
      r_out_ovf  <= 1'b0;
    end else if (w_adv) begin
      r_vld_pipe <= {r_vld_pipe[STAGES-1:0], in_valid};
      r_x0       <= in_data;
      r_out_data <= w_out;
      r_out_ovf  <= w_ovf;
    end
  end
endmodule
